// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time over a
// variable-latency req/rvalid handshake and feeds IF/ID with instruction, PC+4 and flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_flush
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;

  logic [31:0] w_pc_plus4;
  logic        w_resp;
  logic        w_b2b;
  logic        w_busy_after;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_resp     = (r_state == S_WAIT) && imem_rvalid;
  // A consumed response immediately launches the next read unless ID redirects.
  assign w_b2b      = w_resp && pc_write && !redirect;

  // A request is still in flight after this cycle (the ISSUE one, or an unanswered one).
  assign w_busy_after = (r_state == S_ISSUE) ||
                        (((r_state == S_WAIT) || (r_state == S_DROP)) && !imem_rvalid);

  assign imem_req  = (r_state == S_ISSUE) || w_b2b;
  assign imem_addr = w_b2b ? w_pc_plus4 : r_pc;
  assign if_pc     = w_pc_plus4;
  assign if_flush  = redirect && !rst;

  always_comb begin
    if_inst = NOP_INST;
    if (w_resp)
      if_inst = imem_rdata;
    else if (r_state == S_HOLD)
      if_inst = r_inst_buf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inst_buf <= NOP_INST;
    end else if (redirect) begin
      r_pc    <= redirect_pc;
      r_state <= w_busy_after ? S_DROP : S_ISSUE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_ISSUE;
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (pc_write) begin
              r_pc <= w_pc_plus4;
            end else begin
              r_inst_buf <= imem_rdata;
              r_state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (pc_write) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_ISSUE;
          end
        end
        S_DROP: begin
          if (imem_rvalid)
            r_state <= S_ISSUE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory responder plus a transaction-level
// reference model of the fetch stage, directed scenarios followed by random traffic.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] XKEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_flush;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_write    (pc_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_flush    (if_flush)
  );

  initial forever #5 clk = ~clk;

  // Memory: answers each request after mem_lat cycles (or a random 1..4) with addr^XKEY.
  int          mem_lat  = 1;
  bit          mem_rand = 1'b0;
  int          mem_cnt;
  logic [31:0] mem_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt  <= 0;
      mem_data <= 32'h0;
    end else if (imem_req) begin
      mem_cnt  <= mem_rand ? int'($urandom_range(4, 1)) : mem_lat;
      mem_data <= imem_addr ^ XKEY;
    end else if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  assign imem_rvalid = (mem_cnt == 1);
  assign imem_rdata  = imem_rvalid ? mem_data : 32'hDEAD_BEEF;

  // Reference model: PC, held instruction, in-flight read (and whether it was cancelled).
  logic [31:0] m_pc, m_buf;
  bit          m_out, m_stale, m_need, m_hold, m_start;
  bit          c_rv, c_pw, c_rd, c_req;
  logic [31:0] c_rdata, c_rpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_buf = NOP;
    m_out = 0; m_stale = 0; m_need = 0; m_hold = 0; m_start = 1;
  endtask

  task automatic drive(input bit pw, input bit rd, input logic [31:0] rpc);
    bit resp, b2b;
    pc_write = pw; redirect = rd; redirect_pc = rpc;
    #1;
    c_rv = imem_rvalid; c_rdata = imem_rdata; c_pw = pw; c_rd = rd; c_rpc = rpc;
    resp  = c_rv && m_out;
    b2b   = resp && !m_stale && pw && !rd;
    c_req = m_need || b2b;
    chk("imem_req", 32'(imem_req), 32'(c_req));
    if (c_req) chk("imem_addr", imem_addr, b2b ? m_pc + 32'd4 : m_pc);
    chk("if_pc", if_pc, m_pc + 32'd4);
    chk("if_inst", if_inst, (resp && !m_stale) ? c_rdata : (m_hold ? m_buf : NOP));
    chk("if_flush", 32'(if_flush), 32'(rd));
  endtask

  task automatic tick();
    bit resp, out_after, nxt_need;
    @(posedge clk);
    resp      = c_rv && m_out;
    out_after = (m_out && !c_rv) || c_req;
    if (c_rd) begin
      m_pc = c_rpc; m_hold = 0; m_start = 0;
      m_stale = out_after;
      m_need  = !out_after;
    end else begin
      nxt_need = m_start;
      m_start  = 0;
      if (resp) begin
        if (m_stale) begin
          m_stale  = 0;
          nxt_need = 1;
        end else if (c_pw) begin
          m_pc = m_pc + 32'd4;
        end else begin
          m_hold = 1; m_buf = c_rdata;
        end
      end else if (m_hold && c_pw) begin
        m_pc = m_pc + 32'd4; m_hold = 0; nxt_need = 1;
      end
      m_need = nxt_need;
    end
    m_out = out_after;
    #1;
  endtask

  task automatic step(input bit pw, input bit rd, input logic [31:0] rpc);
    drive(pw, rd, rpc);
    tick();
  endtask

  initial begin
    bit found;
    model_reset();

    // Reset values, flush masked while rst is high
    rst = 1; pc_write = 1; redirect = 1; redirect_pc = 32'h1234;
    @(posedge clk); #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_if_pc", if_pc, RPC + 32'd4);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_flush", 32'(if_flush), 32'h0);
    redirect = 0;
    @(posedge clk); #1;
    rst = 0;

    // L=1 start-up, then stall three cycles when 0x8 arrives
    drive(1, 0, 0); chk("idle_no_req", 32'(imem_req), 32'h0); tick();
    drive(1, 0, 0); chk("first_req", 32'(imem_req), 32'h1); chk("first_addr", imem_addr, 32'h0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0);
      chk("l1_inst", if_inst, XKEY | 32'(i * 4));
      chk("l1_pc", if_pc, 32'(i * 4 + 4));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      chk("stall_inst", if_inst, XKEY | 32'h8);
      chk("stall_pc", if_pc, 32'd12);
      chk("stall_noreq", 32'(imem_req), 32'h0);
      tick();
    end
    drive(1, 0, 0); chk("hold_release_noreq", 32'(imem_req), 32'h0); tick();
    drive(1, 0, 0); chk("resume_req", 32'(imem_req), 32'h1); chk("resume_addr", imem_addr, 32'd12); tick();
    repeat (8) step(1, 0, 0);

    // L=3 steady state
    mem_lat = 3;
    repeat (15) step(1, 0, 0);

    // Redirect while waiting on memory: stale response dropped, then fetch 0x100
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_out && !m_stale && !m_need && !imem_rvalid) begin
        drive(1, 1, 32'h100); chk("redir_flush", 32'(if_flush), 32'h1); tick();
        for (int j = 0; j < 8 && !found; j++) begin
          drive(1, 0, 0);
          if (c_rv) begin
            chk("stale_inst", if_inst, NOP);
            tick();
            drive(1, 0, 0);
            chk("redir_req", 32'(imem_req), 32'h1);
            chk("redir_addr", imem_addr, 32'h100);
            tick();
            found = 1;
          end else tick();
        end
      end else step(1, 0, 0);
    end
    chk("redir_wait_scenario", 32'(found), 32'h1);

    // Redirect, stall and response in the same cycle: redirect wins
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_rvalid && m_out && !m_stale) begin
        drive(0, 1, 32'h200); tick();
        drive(1, 0, 0);
        chk("prio_req", 32'(imem_req), 32'h1);
        chk("prio_addr", imem_addr, 32'h200);
        chk("prio_no_hold", if_inst, NOP);
        tick();
        found = 1;
      end else step(1, 0, 0);
    end
    chk("prio_scenario", 32'(found), 32'h1);

    // PC wrap at the top of the address space
    mem_lat = 1;
    step(1, 1, 32'hFFFF_FFFC);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_need) begin
        drive(1, 0, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_if_pc", if_pc, 32'h0);
        tick();
        drive(1, 0, 0);
        chk("wrap_next_req", 32'(imem_req), 32'h1);
        chk("wrap_next_addr", imem_addr, 32'h0);
        tick();
        found = 1;
      end else step(1, 0, 0);
    end
    chk("wrap_scenario", 32'(found), 32'h1);

    // Asynchronous reset while waiting at pc=0x40
    mem_lat = 3;
    step(1, 1, 32'h40);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_out && !m_stale && !m_need && !imem_rvalid && m_pc == 32'h40) begin
        rst = 1; #1;
        chk("arst_req", 32'(imem_req), 32'h0);
        chk("arst_addr", imem_addr, RPC);
        chk("arst_if_pc", if_pc, RPC + 32'd4);
        chk("arst_if_inst", if_inst, NOP);
        chk("arst_flush", 32'(if_flush), 32'h0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        drive(1, 0, 0); chk("arst_idle", 32'(imem_req), 32'h0); tick();
        drive(1, 0, 0); chk("arst_req2", 32'(imem_req), 32'h1); chk("arst_addr2", imem_addr, RPC); tick();
        found = 1;
      end else step(1, 0, 0);
    end
    chk("arst_scenario", 32'(found), 32'h1);

    // Random traffic: random latency, stalls and redirects (some unaligned)
    mem_rand = 1;
    repeat (400) begin
      bit pw, rd;
      logic [31:0] rpc;
      pw  = ($urandom_range(3, 0) != 0);
      rd  = ($urandom_range(11, 0) == 0);
      rpc = $urandom();
      if ($urandom_range(7, 0) != 0) rpc = rpc & 32'hFFFF_FFFC;
      step(pw, rd, rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
